sqemux_sel_ctrl: RTL and testbench



---
 rtl/sqemux_pkg.sv | 21 ++
 rtl/sqemux_sync.sv | 31 +++
 rtl/sqemux_sel_ctrl.sv | 112 +++++++++++
 tb/tb_sqemux_sel_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqemux_pkg.sv
// Shared types and constants for the quad-clock select-mux control glue.
package sqemux_pkg;

    // Width of the gate/settle cycle counter.
    localparam int CNT_W = 8;

    // Mux source encodings as seen on the SELECT pin.
    localparam logic SEL_QMUXIN = 1'b0;
    localparam logic SEL_SQHSCK = 1'b1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Switch sequence phases.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        SETTLE   = 2'd3
    } state_t;

endpackage

// File: rtl/sqemux_sync.sv
// N-stage synchroniser with a programmable reset value, used for async
// control inputs entering the control-clock domain.
module sqemux_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sqemux_sync: STAGES=%0d outside 2..4", STAGES);
    end

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sqemux_sel_ctrl.sv
// Glitch-free select sequencer for the quad-clock select mux: gates the mux
// output off, toggles SELECT, waits for it to settle, then re-enables.
module sqemux_sel_ctrl
    import sqemux_pkg::*;
#(
    parameter logic RESET_SEL     = SEL_QMUXIN,
    parameter int   GATE_CYCLES   = 4,
    parameter int   SETTLE_CYCLES = 4,
    parameter int   SYNC_STAGES   = 2
) (
    input  logic QCK,
    input  logic QRT,
    input  logic REQ_SEL,
    input  logic DYN_MODE,
    output logic SELECT,
    output logic SEN,
    output logic DEN,
    output logic DYNEN,
    output logic BUSY,
    output logic DONE
);

    if (GATE_CYCLES < 1 || GATE_CYCLES > 255) begin : g_bad_gate
        $error("sqemux_sel_ctrl: GATE_CYCLES=%0d outside 1..255", GATE_CYCLES);
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("sqemux_sel_ctrl: SETTLE_CYCLES=%0d outside 1..255", SETTLE_CYCLES);
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("sqemux_sel_ctrl: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
    end

    // Counter reload values; the counter runs down to zero inclusive.
    localparam cnt_t GATE_LOAD   = cnt_t'(GATE_CYCLES - 1);
    localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 1);

    state_t state;
    cnt_t   cnt;
    logic   req_s;

    sqemux_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_SEL)
    ) u_req_sync (
        .clk (QCK),
        .rst (QRT),
        .d   (REQ_SEL),
        .q   (req_s)
    );

    // The dynamic-enable path of the mux is not used by this sequencer.
    assign DEN = 1'b0;

    // Register the dynamic-switching enable; one cycle of latency.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            DYNEN <= 1'b0;
        end else begin
            DYNEN <= DYN_MODE;
        end
    end

    // Switch sequencer: gate off, toggle SELECT, settle, re-enable.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state  <= IDLE;
            cnt    <= '0;
            SELECT <= RESET_SEL;
            SEN    <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (DYNEN && (req_s != SELECT)) begin
                        state <= GATE_OFF;
                        SEN   <= 1'b0;
                        BUSY  <= 1'b1;
                        cnt   <= GATE_LOAD;
                    end
                end
                GATE_OFF: begin
                    if (cnt == '0) begin
                        state <= SWITCH;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                SWITCH: begin
                    // Toggle rather than copy req_s: a reverted request is
                    // handled by a fresh sequence from IDLE.
                    SELECT <= ~SELECT;
                    cnt    <= SETTLE_LOAD;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        SEN   <= 1'b1;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqemux_sel_ctrl.sv
// Directed bench for sqemux_sel_ctrl. Instance A uses default timing with
// RESET_SEL = 0; instance B uses RESET_SEL = 1 with 1-cycle gate/settle.
module tb_sqemux_sel_ctrl;

    localparam int G = 4;
    localparam int S = 4;

    logic clk;
    logic rst_a, req_a, dyn_a;
    logic sel_a, sen_a, den_a, dynen_a, busy_a, done_a;
    logic rst_b, req_b, dyn_b;
    logic sel_b, sen_b, den_b, dynen_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int glitch_a  = 0;
    int glitch_b  = 0;
    int win_b     = 0;
    int win_err_b = 0;
    int run_b     = 0;
    logic prev_sel_a, prev_sen_a, prev_sel_b, prev_sen_b;

    sqemux_sel_ctrl #(
        .RESET_SEL     (1'b0),
        .GATE_CYCLES   (G),
        .SETTLE_CYCLES (S),
        .SYNC_STAGES   (2)
    ) u_dut_a (
        .QCK      (clk),
        .QRT      (rst_a),
        .REQ_SEL  (req_a),
        .DYN_MODE (dyn_a),
        .SELECT   (sel_a),
        .SEN      (sen_a),
        .DEN      (den_a),
        .DYNEN    (dynen_a),
        .BUSY     (busy_a),
        .DONE     (done_a)
    );

    sqemux_sel_ctrl #(
        .RESET_SEL     (1'b1),
        .GATE_CYCLES   (1),
        .SETTLE_CYCLES (1),
        .SYNC_STAGES   (2)
    ) u_dut_b (
        .QCK      (clk),
        .QRT      (rst_b),
        .REQ_SEL  (req_b),
        .DYN_MODE (dyn_b),
        .SELECT   (sel_b),
        .SEN      (sen_b),
        .DEN      (den_b),
        .DYNEN    (dynen_b),
        .BUSY     (busy_b),
        .DONE     (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and update the running monitors.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_a && (sel_a !== prev_sel_a) && (prev_sen_a !== 1'b0 || sen_a !== 1'b0)) glitch_a++;
        if (!rst_b && (sel_b !== prev_sel_b) && (prev_sen_b !== 1'b0 || sen_b !== 1'b0)) glitch_b++;
        if (sen_b === 1'b0) begin
            run_b++;
        end else if (run_b != 0) begin
            win_b++;
            if (run_b != 3) win_err_b++;
            run_b = 0;
        end
        prev_sel_a = sel_a;
        prev_sen_a = sen_a;
        prev_sel_b = sel_b;
        prev_sen_b = sen_b;
    endtask

    initial begin
        int base, t_fall, t_sel, t_rise, n_done, n_busy, n_low, n_chg;
        int f1, f2, d1, d2;
        logic sel_d1, last_sen, last_sel;

        rst_a = 1'b1; req_a = 1'b0; dyn_a = 1'b1;
        rst_b = 1'b1; req_b = 1'b1; dyn_b = 1'b0;
        #1;

        // Reset held for three cycles; outputs settle on the first edge.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_b_select", sel_b, 1);
            check("rst_b_sen",    sen_b, 1);
            check("rst_b_den",    den_b, 0);
            check("rst_b_dynen",  dynen_b, 0);
            check("rst_b_busy",   busy_b, 0);
            check("rst_b_done",   done_b, 0);
        end
        check("rst_a_select", sel_a, 0);
        check("rst_a_sen",    sen_a, 1);
        check("rst_a_dynen",  dynen_a, 0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4) tick();
        check("idle_a_select", sel_a, 0);
        check("idle_a_sen",    sen_a, 1);
        check("idle_a_busy",   busy_a, 0);
        check("idle_a_dynen",  dynen_a, 1);

        // Basic switch 0 -> 1.
        req_a = 1'b1;
        base = cyc; t_fall = -1; t_sel = -1; t_rise = -1; n_done = 0; n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sen_a === 1'b0 && t_fall < 0) t_fall = cyc - base;
            if (sel_a === 1'b1 && t_sel < 0) t_sel = cyc - base;
            if (sen_a === 1'b1 && t_fall >= 0 && t_rise < 0) t_rise = cyc - base;
            if (done_a === 1'b1) n_done++;
            if (busy_a === 1'b1) n_busy++;
        end
        check("basic_sen_fall",     t_fall, 3);
        check("basic_select_rise",  t_sel, 3 + G + 1);
        check("basic_sen_rise",     t_rise, 3 + G + 1 + S);
        check("basic_done_pulses",  n_done, 1);
        check("basic_busy_cycles",  n_busy, G + 1 + S);
        check("basic_final_select", sel_a, 1);
        check("basic_den",          den_a, 0);

        // Revert mid-sequence: request drops two cycles into GATE_OFF.
        rst_a = 1'b1; req_a = 1'b0;
        tick();
        rst_a = 1'b0;
        check("rev_reset_select", sel_a, 0);
        repeat (2) tick();
        req_a = 1'b1;
        base = cyc; f1 = -1; f2 = -1; d1 = -1; d2 = -1; n_done = 0;
        sel_d1 = 1'bx; last_sen = sen_a;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (cyc - base == 5) req_a = 1'b0;
            if (last_sen === 1'b1 && sen_a === 1'b0) begin
                if (f1 < 0) f1 = cyc - base;
                else if (f2 < 0) f2 = cyc - base;
            end
            if (done_a === 1'b1) begin
                n_done++;
                if (d1 < 0) begin
                    d1 = cyc - base;
                    sel_d1 = sel_a;
                end else if (d2 < 0) begin
                    d2 = cyc - base;
                end
            end
            last_sen = sen_a;
        end
        check("rev_done_pulses",   n_done, 2);
        check("rev_done1_cycle",   d1, 3 + G + 1 + S);
        check("rev_select_at_d1",  sel_d1, 1);
        check("rev_start_spacing", f2 - f1, 1 + G + 1 + S);
        check("rev_done2_cycle",   d2, 3 + 2 * (G + 1 + S) + 1);
        check("rev_final_select",  sel_a, 0);

        // Static hold: mismatching requests with dynamic switching off.
        dyn_a = 1'b0;
        repeat (2) tick();
        check("static_dynen", dynen_a, 0);
        n_chg = 0; n_low = 0; n_busy = 0; last_sel = sel_a;
        for (int k = 0; k < 5; k++) begin
            req_a = ~req_a;
            repeat (3) begin
                tick();
                if (sel_a !== last_sel) n_chg++;
                if (sen_a !== 1'b1) n_low++;
                if (busy_a !== 1'b0) n_busy++;
            end
        end
        repeat (6) begin
            tick();
            if (sel_a !== last_sel) n_chg++;
            if (sen_a !== 1'b1) n_low++;
            if (busy_a !== 1'b0) n_busy++;
        end
        check("static_select_changes", n_chg, 0);
        check("static_sen_low",        n_low, 0);
        check("static_busy",           n_busy, 0);

        // DYN_MODE drops mid-sequence: the sequence still completes.
        dyn_a = 1'b1;
        base = cyc; t_fall = -1; t_rise = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cyc - base == 4) dyn_a = 1'b0;
            if (sen_a === 1'b0 && t_fall < 0) t_fall = cyc - base;
            if (sen_a === 1'b1 && t_fall >= 0 && t_rise < 0) t_rise = cyc - base;
        end
        check("dyn_sen_fall",     t_fall, 2);
        check("dyn_sen_rise",     t_rise, 2 + G + 1 + S);
        check("dyn_final_select", sel_a, 1);
        req_a = 1'b0;
        n_low = 0;
        repeat (12) begin
            tick();
            if (sen_a !== 1'b1) n_low++;
        end
        check("dyn_hold_sen_low", n_low, 0);
        check("dyn_hold_select",  sel_a, 1);

        // Reset in SETTLE with SEN low.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        req_a = 1'b1; dyn_a = 1'b1;
        repeat (9) tick();
        check("mid_pre_sen",    sen_a, 0);
        check("mid_pre_select", sel_a, 1);
        rst_a = 1'b1;
        tick();
        check("mid_rst_sen",    sen_a, 1);
        check("mid_rst_select", sel_a, 0);
        check("mid_rst_busy",   busy_a, 0);
        check("mid_rst_done",   done_a, 0);
        rst_a = 1'b0;
        n_done = 0;
        repeat (3) begin
            tick();
            if (done_a !== 1'b0) n_done++;
        end
        check("mid_no_done", n_done, 0);
        dyn_a = 1'b0;

        // Random toggling on the fast instance.
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 2))
                0: req_b = ~req_b;
                1: dyn_b = ~dyn_b;
                default: begin
                    req_b = ~req_b;
                    dyn_b = ~dyn_b;
                end
            endcase
            repeat ($urandom_range(1, 4)) tick();
        end
        dyn_b = 1'b0;
        repeat (20) tick();
        check("rnd_glitch_b",      glitch_b, 0);
        check("rnd_window_len",    win_err_b, 0);
        check("rnd_windows_seen",  win_b > 20, 1);
        check("rnd_final_sen",     sen_b, 1);
        check("dir_glitch_a",      glitch_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
